// File: rtl/schmitt_inv_filt.sv
// Multi-channel inverter/buffer with clocked hysteresis: each input is synchronised,
// integrated in a saturating up/down counter, and the output flips only at saturation.
module schmitt_inv_filt #(
    parameter int CHANNELS    = 6,
    parameter int HYST        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int INVERT      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] byp,
    output logic [CHANNELS-1:0] y,
    output logic [CHANNELS-1:0] chg
);

    localparam int CW = (HYST < 1) ? 1 : $clog2(HYST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HYST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CHANNELS-1:0] INV_MASK = (INVERT != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    logic [CHANNELS-1:0]         s;
    logic [CHANNELS-1:0][CW-1:0] cnt_q;
    logic [CHANNELS-1:0][CW-1:0] cnt_d;
    logic [CHANNELS-1:0]         state_q;
    logic [CHANNELS-1:0]         state_d;
    logic [CHANNELS-1:0]         chg_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = a;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;

            // Input synchroniser chain; the last stage feeds the integrators.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= {(SYNC_STAGES*CHANNELS){1'b0}};
                end else begin
                    sync_q[0] <= a;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Saturating integrator and threshold decision; the state holds between thresholds.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (!s[i] && (cnt_q[i] != CNT_ZERO)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            if (cnt_d[i] == CNT_MAX) begin
                state_d[i] = 1'b1;
            end else if (cnt_d[i] == CNT_ZERO) begin
                state_d[i] = 1'b0;
            end else begin
                state_d[i] = state_q[i];
            end
        end
    end

    // Filter state; chg is registered so it lines up with the cycle the new state shows on y.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= {(CHANNELS*CW){1'b0}};
            state_q <= {CHANNELS{1'b0}};
            chg_q   <= {CHANNELS{1'b0}};
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            chg_q   <= state_d ^ state_q;
        end
    end

    // Bypass is deliberately combinational from the raw pin, matching the legacy part.
    assign y   = (byp & (a ^ INV_MASK)) | (~byp & (state_q ^ INV_MASK));
    assign chg = chg_q;

endmodule

// File: tb/tb_schmitt_inv_filt.sv
// Scoreboard bench for schmitt_inv_filt: directed steps push hand-computed outputs,
// a negedge monitor pops and compares them against the selected instance.
module tb_schmitt_inv_filt;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] a;
    logic [5:0] byp;
    logic [5:0] y0, c0, y1, c1, y2, c2;

    always #5 clk = ~clk;

    schmitt_inv_filt #(.CHANNELS(6), .HYST(4), .SYNC_STAGES(2), .INVERT(1)) u_def (
        .clk(clk), .rst(rst), .a(a), .byp(byp), .y(y0), .chg(c0));
    schmitt_inv_filt #(.CHANNELS(6), .HYST(1), .SYNC_STAGES(0), .INVERT(1)) u_fast (
        .clk(clk), .rst(rst), .a(a), .byp(byp), .y(y1), .chg(c1));
    schmitt_inv_filt #(.CHANNELS(6), .HYST(4), .SYNC_STAGES(2), .INVERT(0)) u_buf (
        .clk(clk), .rst(rst), .a(a), .byp(byp), .y(y2), .chg(c2));

    typedef struct packed {
        logic [1:0] dut;   // 0 default, 1 fast, 2 buffer, 3 no check
        logic [3:0] tag;
        logic [5:0] y;
        logic [5:0] c;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    logic [5:0] got_y, got_c;
    int    total = 0;
    int    bad   = 0;
    string names[6] = '{"reset", "latency", "glitch", "hyst", "bypass", "rst_mid"};

    task automatic step(input logic r, input logic [5:0] av, input logic [5:0] bv,
                        input logic [1:0] d, input logic [3:0] t,
                        input logic [5:0] ey, input logic [5:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        a   = av;
        byp = bv;
        e.dut = d;
        e.tag = t;
        e.y   = ey;
        e.c   = ec;
        sb.push_back(e);
    endtask

    task automatic steps(input int n, input logic r, input logic [5:0] av, input logic [5:0] bv,
                         input logic [1:0] d, input logic [3:0] t,
                         input logic [5:0] ey, input logic [5:0] ec);
        for (int i = 0; i < n; i++) begin
            step(r, av, bv, d, t, ey, ec);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.dut)
                2'd0:    begin got_y = y0; got_c = c0; end
                2'd1:    begin got_y = y1; got_c = c1; end
                default: begin got_y = y2; got_c = c2; end
            endcase
            if (mon_e.dut != 2'd3) begin
                total++;
                if (got_y !== mon_e.y || got_c !== mon_e.c) begin
                    bad++;
                    $display("FAIL %s dut=%0d y=%h expected %h chg=%h expected %h",
                             names[int'(mon_e.tag)], mon_e.dut, got_y, mon_e.y, got_c, mon_e.c);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        a   = 6'h00;
        byp = 6'h00;
        repeat (3) @(posedge clk);

        // Default instance: reset and idle
        steps(2,  1'b1, 6'h00, 6'h00, 2'd0, 4'd0, 6'h3F, 6'h00);
        steps(20, 1'b0, 6'h00, 6'h00, 2'd0, 4'd0, 6'h3F, 6'h00);

        // Clean step on channel 0: flips on the 6th sampling edge
        steps(6, 1'b0, 6'h01, 6'h00, 2'd0, 4'd1, 6'h3F, 6'h00);
        step(    1'b0, 6'h01, 6'h00, 2'd0, 4'd1, 6'h3E, 6'h01);
        steps(3, 1'b0, 6'h01, 6'h00, 2'd0, 4'd1, 6'h3E, 6'h00);

        // 3-cycle glitch on channel 1 is rejected
        steps(3,  1'b0, 6'h03, 6'h00, 2'd0, 4'd2, 6'h3E, 6'h00);
        steps(12, 1'b0, 6'h01, 6'h00, 2'd0, 4'd2, 6'h3E, 6'h00);
        // Counter back at 0: a held level needs the full latency again
        steps(6, 1'b0, 6'h03, 6'h00, 2'd0, 4'd2, 6'h3E, 6'h00);
        step(    1'b0, 6'h03, 6'h00, 2'd0, 4'd2, 6'h3C, 6'h02);
        steps(2, 1'b0, 6'h03, 6'h00, 2'd0, 4'd2, 6'h3C, 6'h00);
        steps(6, 1'b0, 6'h01, 6'h00, 2'd0, 4'd2, 6'h3C, 6'h00);
        step(    1'b0, 6'h01, 6'h00, 2'd0, 4'd2, 6'h3E, 6'h02);
        steps(3, 1'b0, 6'h01, 6'h00, 2'd0, 4'd2, 6'h3E, 6'h00);

        // Hysteresis: short low dip on channel 0 does not release it
        steps(3,  1'b0, 6'h00, 6'h00, 2'd0, 4'd3, 6'h3E, 6'h00);
        steps(10, 1'b0, 6'h01, 6'h00, 2'd0, 4'd3, 6'h3E, 6'h00);
        steps(6,  1'b0, 6'h00, 6'h00, 2'd0, 4'd3, 6'h3E, 6'h00);
        step(     1'b0, 6'h00, 6'h00, 2'd0, 4'd3, 6'h3F, 6'h01);
        steps(2,  1'b0, 6'h00, 6'h00, 2'd0, 4'd3, 6'h3F, 6'h00);

        // Bypass: immediate output, filter keeps running underneath
        steps(6, 1'b0, 6'h15, 6'h3F, 2'd0, 4'd4, 6'h2A, 6'h00);
        step(    1'b0, 6'h15, 6'h3F, 2'd0, 4'd4, 6'h2A, 6'h15);
        steps(2, 1'b0, 6'h15, 6'h3F, 2'd0, 4'd4, 6'h2A, 6'h00);
        steps(2, 1'b0, 6'h15, 6'h00, 2'd0, 4'd4, 6'h2A, 6'h00);
        steps(6, 1'b0, 6'h00, 6'h3F, 2'd0, 4'd4, 6'h3F, 6'h00);
        step(    1'b0, 6'h00, 6'h3F, 2'd0, 4'd4, 6'h3F, 6'h15);
        steps(2, 1'b0, 6'h00, 6'h00, 2'd0, 4'd4, 6'h3F, 6'h00);

        // Reset mid-count (first vector also checks a mixed bypass mask)
        step(    1'b0, 6'h3F, 6'h0F, 2'd0, 4'd4, 6'h30, 6'h00);
        steps(4, 1'b0, 6'h3F, 6'h00, 2'd0, 4'd5, 6'h3F, 6'h00);
        step(    1'b1, 6'h3F, 6'h00, 2'd0, 4'd5, 6'h3F, 6'h00);
        steps(6, 1'b0, 6'h3F, 6'h00, 2'd0, 4'd5, 6'h3F, 6'h00);
        step(    1'b0, 6'h3F, 6'h00, 2'd0, 4'd5, 6'h00, 6'h3F);
        steps(2, 1'b0, 6'h3F, 6'h00, 2'd0, 4'd5, 6'h00, 6'h00);

        // HYST=1, no synchroniser: one-cycle follow, no rejection
        step(    1'b1, 6'h00, 6'h00, 2'd3, 4'd0, 6'h00, 6'h00);
        steps(2, 1'b1, 6'h00, 6'h00, 2'd1, 4'd0, 6'h3F, 6'h00);
        steps(3, 1'b0, 6'h00, 6'h00, 2'd1, 4'd0, 6'h3F, 6'h00);
        step(    1'b0, 6'h01, 6'h00, 2'd1, 4'd1, 6'h3F, 6'h00);
        step(    1'b0, 6'h01, 6'h00, 2'd1, 4'd1, 6'h3E, 6'h01);
        steps(2, 1'b0, 6'h01, 6'h00, 2'd1, 4'd1, 6'h3E, 6'h00);
        step(    1'b0, 6'h03, 6'h00, 2'd1, 4'd2, 6'h3E, 6'h00);
        step(    1'b0, 6'h03, 6'h00, 2'd1, 4'd2, 6'h3C, 6'h02);
        step(    1'b0, 6'h03, 6'h00, 2'd1, 4'd2, 6'h3C, 6'h00);
        step(    1'b0, 6'h01, 6'h00, 2'd1, 4'd2, 6'h3C, 6'h00);
        step(    1'b0, 6'h01, 6'h00, 2'd1, 4'd2, 6'h3E, 6'h02);
        step(    1'b0, 6'h01, 6'h00, 2'd1, 4'd2, 6'h3E, 6'h00);

        // INVERT=0: buffer polarity
        step(     1'b1, 6'h00, 6'h00, 2'd3, 4'd0, 6'h00, 6'h00);
        steps(2,  1'b1, 6'h00, 6'h00, 2'd2, 4'd0, 6'h00, 6'h00);
        steps(3,  1'b0, 6'h00, 6'h00, 2'd2, 4'd0, 6'h00, 6'h00);
        steps(6,  1'b0, 6'h01, 6'h00, 2'd2, 4'd1, 6'h00, 6'h00);
        step(     1'b0, 6'h01, 6'h00, 2'd2, 4'd1, 6'h01, 6'h01);
        steps(2,  1'b0, 6'h01, 6'h00, 2'd2, 4'd1, 6'h01, 6'h00);
        steps(3,  1'b0, 6'h03, 6'h00, 2'd2, 4'd2, 6'h01, 6'h00);
        steps(10, 1'b0, 6'h01, 6'h00, 2'd2, 4'd2, 6'h01, 6'h00);
        step(     1'b0, 6'h15, 6'h15, 2'd2, 4'd4, 6'h15, 6'h00);

        for (int w = 0; w < 10 && sb.size() > 0; w++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
